alu_addsub_pipe: RTL

//  Parametrised, pipelined Y86 OPq execute unit (addq/subq/andq/xorq) for the EX stage.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_chunk_slice.sv | 39 +++
 rtl/alu_addsub_pipe.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and condition-code bit positions for the pipelined
// Y86 OPq execute unit.
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_XOR = 2'd3;

    localparam int ZF_BIT = 2;
    localparam int SF_BIT = 1;
    localparam int OF_BIT = 0;

endpackage

// File: rtl/alu_chunk_slice.sv
// One CHUNK-bit slice of the OPq datapath: add/sub with carry in, or a bitwise op.
// The carry out is forced low for logical ops so the chain stays quiet.
module alu_chunk_slice
    import alu_pkg::*;
#(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic [CHUNK-1:0] r,
    output logic             cout,
    output logic             zero
);

    logic             sub;
    logic             arith;
    logic [CHUNK-1:0] b_eff;
    logic [CHUNK:0]   sum;

    assign sub   = (op == ALU_SUB);
    assign arith = (op == ALU_ADD) | sub;
    assign b_eff = sub ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {{CHUNK{1'b0}}, cin & arith};

    always_comb begin
        r = sum[CHUNK-1:0];
        case (op)
            ALU_AND: r = a & b;
            ALU_XOR: r = a ^ b;
            default: r = sum[CHUNK-1:0];
        endcase
    end

    assign cout = arith & sum[CHUNK];
    assign zero = ~|r;

endmodule

// File: rtl/alu_addsub_pipe.sv
// Pipelined Y86 OPq unit: one CHUNK slice resolved per stage, carry rippled between stages.
// Optional Y86 condition-code register enabled by defining ALU_PIPE_CC_REG_EN.
module alu_addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r,
    output logic             out_zf,
    output logic             out_sf,
    output logic             out_of,
    output logic             out_cf
`ifdef ALU_PIPE_CC_REG_EN
    ,
    output logic [2:0]       cc_q
`endif
);

    localparam int NSTAGE = WIDTH / CHUNK;

    if (WIDTH % CHUNK != 0) begin : g_width_check
        $error("alu_addsub_pipe: WIDTH must be a multiple of CHUNK");
    end

    logic advance;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance & ~rst;

    genvar gi;
    for (gi = 0; gi < NSTAGE; gi++) begin : g_stage
        localparam int LO  = gi * CHUNK;
        localparam int REM = WIDTH - LO;

        // src_a/src_b hold only the operand bits not yet resolved; bit 0 is this stage's slice.
        logic [REM-1:0]      src_a;
        logic [REM-1:0]      src_b;
        logic [1:0]          src_op;
        logic                src_valid;
        logic                src_cin;
        logic                src_zero;
        logic [CHUNK-1:0]    slice_r;
        logic                slice_cout;
        logic                slice_zero;
        logic [LO+CHUNK-1:0] r_d;
        logic [LO+CHUNK-1:0] r_q;
        logic                valid_q;
        logic                carry_q;
        logic                zero_q;

        if (gi == 0) begin : g_src
            assign src_valid = in_valid & in_ready;
            assign src_op    = in_op;
            assign src_a     = in_a;
            assign src_b     = in_b;
            assign src_cin   = (in_op == ALU_SUB);
            assign src_zero  = 1'b1;
            assign r_d       = slice_r;
        end else begin : g_src
            assign src_valid = g_stage[gi-1].valid_q;
            assign src_op    = g_stage[gi-1].g_fwd.op_q;
            assign src_a     = g_stage[gi-1].g_fwd.a_q;
            assign src_b     = g_stage[gi-1].g_fwd.b_q;
            assign src_cin   = g_stage[gi-1].carry_q;
            assign src_zero  = g_stage[gi-1].zero_q;
            assign r_d       = {slice_r, g_stage[gi-1].r_q};
        end

        alu_chunk_slice #(
            .CHUNK(CHUNK)
        ) u_slice (
            .a    (src_a[CHUNK-1:0]),
            .b    (src_b[CHUNK-1:0]),
            .op   (src_op),
            .cin  (src_cin),
            .r    (slice_r),
            .cout (slice_cout),
            .zero (slice_zero)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                r_q     <= '0;
                carry_q <= 1'b0;
                zero_q  <= 1'b0;
            end else if (advance) begin
                valid_q <= src_valid;
                r_q     <= r_d;
                carry_q <= slice_cout;
                zero_q  <= src_zero & slice_zero;
            end
        end

        if (gi < NSTAGE - 1) begin : g_fwd
            logic [REM-CHUNK-1:0] a_q;
            logic [REM-CHUNK-1:0] b_q;
            logic [1:0]           op_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q  <= '0;
                    b_q  <= '0;
                    op_q <= ALU_ADD;
                end else if (advance) begin
                    a_q  <= src_a[REM-1:CHUNK];
                    b_q  <= src_b[REM-1:CHUNK];
                    op_q <= src_op;
                end
            end
        end else begin : g_last
            logic sub;
            logic arith;
            logic of_d;
            logic of_q;

            // Overflow: operand signs agree (after SUB inversion) but result sign differs.
            assign sub   = (src_op == ALU_SUB);
            assign arith = (src_op == ALU_ADD) | sub;
            assign of_d  = arith & (src_a[REM-1] == (src_b[REM-1] ^ sub))
                                 & (slice_r[CHUNK-1] != src_a[REM-1]);

            always_ff @(posedge clk) begin
                if (rst) begin
                    of_q <= 1'b0;
                end else if (advance) begin
                    of_q <= of_d;
                end
            end
        end
    end

    assign out_valid = g_stage[NSTAGE-1].valid_q;
    assign out_r     = g_stage[NSTAGE-1].r_q;
    assign out_zf    = g_stage[NSTAGE-1].zero_q;
    assign out_sf    = out_r[WIDTH-1];
    assign out_of    = g_stage[NSTAGE-1].g_last.of_q;
    assign out_cf    = g_stage[NSTAGE-1].carry_q;

`ifdef ALU_PIPE_CC_REG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q <= 3'b100;
        end else if (out_valid && out_ready) begin
            cc_q[ZF_BIT] <= out_zf;
            cc_q[SF_BIT] <= out_sf;
            cc_q[OF_BIT] <= out_of;
        end
    end
`endif

endmodule
